// File: rtl/io_arb_pkg.sv
// Shared definitions for the IO arbiter: FSM states, requester IDs and address alignment.
package io_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } arb_state_t;

  typedef enum logic {
    REQ_CPU = 1'b0,
    REQ_DEV = 1'b1
  } req_id_t;

  localparam logic [31:0] WORD_ALIGN_MASK = 32'hFFFF_FFFC;

  // Truncate to the IO window (wraps within 2**aw bytes) and force word alignment.
  function automatic logic [31:0] io_word_addr(input logic [31:0] a, input int unsigned aw);
    return a & ((32'd1 << aw) - 32'd1) & WORD_ALIGN_MASK;
  endfunction

endpackage

// File: rtl/io_irq_latch.sv
// Device interrupt latch: rising dev_irq sets pending, rising INT_ACK clears it; set wins.
module io_irq_latch
  import io_arb_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic dev_irq,
  input  logic INT_ACK,
  output logic INTR
);

  logic r_irq_d;
  logic r_ack_d;
  logic r_pending;
  logic w_irq_rise;
  logic w_ack_rise;

  assign w_irq_rise = dev_irq & ~r_irq_d;
  assign w_ack_rise = INT_ACK & ~r_ack_d;
  assign INTR       = r_pending;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_irq_d   <= 1'b0;
      r_ack_d   <= 1'b0;
      r_pending <= 1'b0;
    end else begin
      r_irq_d <= dev_irq;
      r_ack_d <= INT_ACK;
      if (w_irq_rise)      r_pending <= 1'b1;
      else if (w_ack_rise) r_pending <= 1'b0;
    end
  end

endmodule

// File: rtl/io_arbiter.sv
// Two-requester (CPU/device) round-robin arbiter for a word-addressed IO memory.
// Optional interrupt latch enabled by defining IO_ARB_IRQ_EN.
module io_arbiter
  import io_arb_pkg::*;
#(
  parameter int unsigned ADDR_W  = 12,
  parameter int unsigned SLICE_W = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               cpu_req,
  input  logic               cpu_wr,
  input  logic [31:0]        cpu_addr,
  input  logic [SLICE_W-1:0] cpu_wdata,
  output logic               cpu_gnt,
  output logic               cpu_done,
  input  logic               dev_req,
  input  logic               dev_wr,
  input  logic [31:0]        dev_addr,
  input  logic [SLICE_W-1:0] dev_wdata,
  output logic               dev_gnt,
  output logic               dev_done,
  output logic [SLICE_W-1:0] rdata,
  output logic               io_cs,
  output logic               io_wr,
  output logic               io_rd,
  output logic [31:0]        io_addr,
  output logic [SLICE_W-1:0] io_din,
  input  logic [SLICE_W-1:0] io_dout,
  input  logic               dev_irq,
  input  logic               INT_ACK,
  output logic               INTR
);

  arb_state_t         r_state;
  req_id_t            r_last;
  req_id_t            r_owner;
  logic               r_cs;
  logic               r_wr;
  logic               r_rd;
  req_id_t            w_winner;
  logic               w_sel_wr;
  logic [31:0]        w_sel_addr;
  logic [SLICE_W-1:0] w_sel_wdata;

  // Strobes are masked by reset so an aborted write never reaches memory at the reset edge.
  assign io_cs = r_cs & reset;
  assign io_wr = r_wr & reset;
  assign io_rd = r_rd & reset;

  always_comb begin
    w_winner = REQ_CPU;
    if (cpu_req && dev_req) w_winner = (r_last == REQ_CPU) ? REQ_DEV : REQ_CPU;
    else if (dev_req)       w_winner = REQ_DEV;
    w_sel_wr    = (w_winner == REQ_DEV) ? dev_wr    : cpu_wr;
    w_sel_addr  = (w_winner == REQ_DEV) ? dev_addr  : cpu_addr;
    w_sel_wdata = (w_winner == REQ_DEV) ? dev_wdata : cpu_wdata;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state  <= IDLE;
      r_last   <= REQ_DEV;
      r_owner  <= REQ_CPU;
      r_cs     <= 1'b0;
      r_wr     <= 1'b0;
      r_rd     <= 1'b0;
      io_addr  <= '0;
      io_din   <= '0;
      rdata    <= '0;
      cpu_gnt  <= 1'b0;
      dev_gnt  <= 1'b0;
      cpu_done <= 1'b0;
      dev_done <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          cpu_done <= 1'b0;
          dev_done <= 1'b0;
          if (cpu_req || dev_req) begin
            r_state <= ACCESS;
            r_owner <= w_winner;
            r_last  <= w_winner;
            r_cs    <= 1'b1;
            r_wr    <= w_sel_wr;
            r_rd    <= ~w_sel_wr;
            io_addr <= io_word_addr(w_sel_addr, ADDR_W);
            io_din  <= w_sel_wdata;
            cpu_gnt <= (w_winner == REQ_CPU);
            dev_gnt <= (w_winner == REQ_DEV);
          end
        end
        ACCESS: begin
          r_state  <= DONE;
          r_cs     <= 1'b0;
          r_wr     <= 1'b0;
          r_rd     <= 1'b0;
          if (r_rd) rdata <= io_dout;
          cpu_done <= (r_owner == REQ_CPU);
          dev_done <= (r_owner == REQ_DEV);
        end
        DONE: begin
          r_state  <= IDLE;
          cpu_gnt  <= 1'b0;
          dev_gnt  <= 1'b0;
          cpu_done <= 1'b0;
          dev_done <= 1'b0;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

`ifdef IO_ARB_IRQ_EN
  io_irq_latch u_irq (
    .clk     (clk),
    .reset   (reset),
    .dev_irq (dev_irq),
    .INT_ACK (INT_ACK),
    .INTR    (INTR)
  );
`else
  logic w_unused_irq;
  assign w_unused_irq = dev_irq ^ INT_ACK;
  assign INTR         = 1'b0;
`endif

endmodule

// File: doc/io_arbiter.md
IO_ARBITER -- requirements
Module: io_arbiter

Interface
REQ-001 Parameter: ADDR_W, 12, IO memory byte-address width (4K space).
REQ-002 Parameter: SLICE_W, 32, data word width.
REQ-003 clk  input  1  system clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-low reset.
REQ-005 cpu_req, cpu_wr  input  1 each  CPU request strobe; write(1)/read(0) qualifier.
REQ-006 cpu_addr, cpu_wdata  input  32 each  CPU byte address and write data.
REQ-007 cpu_gnt, cpu_done  output  1 each  CPU granted; one-cycle completion pulse.
REQ-008 dev_req, dev_wr, dev_addr, dev_wdata, dev_gnt, dev_done  same widths/directions as CPU set  second requester (peripheral/DMA).
REQ-009 rdata  output  32  read data returned to the completed requester.
REQ-010 io_cs, io_wr, io_rd  output  1 each  IO memory controls.
REQ-011 io_addr, io_din  output  32 each  IO memory address and write data.
REQ-012 io_dout  input  32  IO memory read data (Hi-Z when not selected).
REQ-013 dev_irq  input  1  device interrupt event; INT_ACK  input  1  CPU acknowledge; INTR  output  1  interrupt request to CPU.

Function
REQ-014 FSM states SHALL be IDLE, ACCESS, DONE; IDLE->ACCESS when any req=1; ACCESS->DONE unconditionally; DONE->IDLE unconditionally.
REQ-015 Arbitration in IDLE SHALL be round-robin: on single request grant it; on simultaneous requests grant the requester not granted last.
REQ-016 Winner's wr, address and wdata SHALL be registered on the IDLE->ACCESS edge; later changes to requester inputs are ignored until DONE.
REQ-017 In ACCESS, io_cs=1 and exactly one of io_wr/io_rd=1; all three SHALL be 0 in IDLE and DONE.
REQ-018 io_addr SHALL be {0, addr[ADDR_W-1:2], 2'b00}: word-aligned, upper bits truncated (wrap within 4K).
REQ-019 Read data SHALL be captured from io_dout on the ACCESS->DONE edge; rdata holds until next read completes.
REQ-020 gnt of the winner SHALL be 1 in ACCESS and DONE; done SHALL pulse 1 for exactly the DONE cycle.
REQ-021 Latency: req sampled at edge k -> ACCESS cycle k+1 -> done in cycle k+2; back-to-back throughput one access per 3 cycles.
REQ-022 Requester dropping req during ACCESS SHALL NOT abort; the transaction completes and done still pulses.
REQ-023 A rising edge of dev_irq SHALL set pending; INTR = pending.
REQ-024 A rising edge of INT_ACK (registered edge detect) SHALL clear pending; simultaneous dev_irq edge and INT_ACK edge SHALL leave pending set.

Reset
REQ-025 When reset=0 at an edge: state=IDLE, last-granted=dev (CPU wins first tie), all gnt/done/io_cs/io_wr/io_rd/INTR=0, io_addr/io_din/rdata=0, pending and edge registers cleared.
REQ-026 Reset asserted during ACCESS SHALL abort; no io_wr at any edge where reset=0; no done pulse for the aborted transaction.

Configuration
REQ-027 Macro IO_ARB_IRQ_EN: defined -> REQ-023/024 implemented; undefined -> INTR tied 0, dev_irq and INT_ACK ignored, no pending logic.

Structure
REQ-028 Shared package io_arb_pkg SHALL hold state encoding (IDLE/ACCESS/DONE), requester IDs (REQ_CPU=0, REQ_DEV=1), and alignment mask constant.
REQ-029 Interrupt logic SHALL be sub-module io_irq_latch (dev_irq, INT_ACK, clk, reset -> INTR).

Verification
REQ-030 CPU write 0xDEADBEEF @0x010 then CPU read @0x010 -> io_wr in ACCESS, later rdata=0xDEADBEEF with cpu_done at edge k+2.
REQ-031 cpu_req and dev_req together from reset -> CPU granted first, device next, alternating while both held.
REQ-032 dev read @0x1003 -> io_addr=0x000, dev_done pulses once.
REQ-033 reset=0 during write ACCESS -> io_cs=0 next cycle, target location unchanged, no done.
REQ-034 dev_irq pulse -> INTR=1 until INT_ACK rise; dev_irq and INT_ACK edges same cycle -> INTR stays 1.
REQ-035 Build without IO_ARB_IRQ_EN, pulse dev_irq -> INTR stays 0.
